vdu_display_ram: RTL and testbench

//  Display memory for the Mk14 VDU, directly upstream of the VDU scanline fetcher. Holds 512 B of
//  RAM at BASE_ADDR and shares one single-port synchronous RAM between two masters. The VDU read

---
 rtl/vdu_display_ram_if.sv | 21 ++
 rtl/vdu_display_ram.sv | 79 +++++++
 tb/tb_vdu_display_ram.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vdu_display_ram_if.sv
// vdu_display_ram_if: CPU req/ack bus and VDU read port of the display RAM
interface vdu_display_ram_if;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_hit;
  logic        o_cpu_ack;
  logic [7:0]  o_cpu_rdata;
  logic        i_vdu_read_en;
  logic [15:0] i_vdu_read_addr;
  logic [7:0]  o_vdu_data;
  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_vdu_read_en, i_vdu_read_addr,
    input  o_cpu_hit, o_cpu_ack, o_cpu_rdata, o_vdu_data
  );
  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_vdu_read_en, i_vdu_read_addr,
    output o_cpu_hit, o_cpu_ack, o_cpu_rdata, o_vdu_data
  );
endinterface

// File: rtl/vdu_display_ram.sv
// vdu_display_ram: single-port display RAM shared by a priority VDU reader and a req/ack CPU
module vdu_display_ram #(
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int unsigned DEPTH     = 512,
  parameter string       INIT_F    = ""
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  vdu_display_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  cpu_rdata_q, vdu_data_q, lat_wdata_q;
  logic [15:0] prev_addr_q, lat_addr_q;
  logic        prev_valid_q, lat_we_q;
  logic [15:0] cpu_off, vdu_off, acc_addr;
  logic [7:0]  acc_wdata;
  logic        cpu_hit, vdu_hit, vdu_use, cpu_go, acc_we, cpu_new;
  assign cpu_off   = bus.i_cpu_addr - BASE_ADDR;
  assign vdu_off   = bus.i_vdu_read_addr - BASE_ADDR;
  assign cpu_hit   = bus.i_cpu_addr >= BASE_ADDR && 32'(cpu_off) < DEPTH;
  assign vdu_hit   = bus.i_vdu_read_addr >= BASE_ADDR && 32'(vdu_off) < DEPTH;
  assign vdu_use   = bus.i_vdu_read_en && vdu_hit &&
                     !(prev_valid_q && bus.i_vdu_read_addr == prev_addr_q);
  assign cpu_new   = state_q == S_IDLE && bus.i_cpu_req && cpu_hit;
  assign cpu_go    = !vdu_use && (cpu_new || state_q == S_WAIT);
  assign acc_addr  = state_q == S_WAIT ? lat_addr_q - BASE_ADDR : cpu_off;
  assign acc_we    = state_q == S_WAIT ? lat_we_q : bus.i_cpu_we;
  assign acc_wdata = state_q == S_WAIT ? lat_wdata_q : bus.i_cpu_wdata;
  assign bus.o_cpu_hit   = cpu_hit;
  assign bus.o_cpu_ack   = state_q == S_ACK;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_vdu_data  = vdu_data_q;
  // CPU grant FSM: immediate grant on a free slot, otherwise wait for one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cpu_new) state_d = vdu_use ? S_WAIT : S_ACK;
      S_WAIT:  if (!vdu_use) state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
  end
  // RAM array write port; contents survive reset
  always_ff @(posedge i_clk_sys) begin
    if (cpu_go && acc_we) mem_q[acc_addr[AW-1:0]] <= acc_wdata;
  end
  // FSM state, CPU latch, VDU read register and repeat tracking
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cpu_rdata_q  <= '0;
      vdu_data_q   <= '0;
      prev_addr_q  <= '0;
      prev_valid_q <= 1'b0;
      lat_addr_q   <= '0;
      lat_we_q     <= 1'b0;
      lat_wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cpu_new && vdu_use) begin
        lat_addr_q  <= bus.i_cpu_addr;
        lat_we_q    <= bus.i_cpu_we;
        lat_wdata_q <= bus.i_cpu_wdata;
      end
      if (cpu_go && !acc_we) cpu_rdata_q <= mem_q[acc_addr[AW-1:0]];
      if (!bus.i_vdu_read_en) prev_valid_q <= 1'b0;
      else if (!vdu_hit) begin
        vdu_data_q   <= '0;
        prev_valid_q <= 1'b0;
      end else if (vdu_use) begin
        vdu_data_q   <= mem_q[vdu_off[AW-1:0]];
        prev_addr_q  <= bus.i_vdu_read_addr;
        prev_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vdu_display_ram.sv
// tb_vdu_display_ram: directed self-checking bench for the shared display RAM
module tb_vdu_display_ram;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [7:0] rd;
  int   lat;
  logic acc;
  vdu_display_ram_if bus();
  vdu_display_ram dut (.i_clk_sys(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] r, output int l);
    bus.i_cpu_req = 1'b1;
    bus.i_cpu_we = we;
    bus.i_cpu_addr = a;
    bus.i_cpu_wdata = d;
    l = -1;
    r = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.o_cpu_ack) begin
        r = bus.o_cpu_rdata;
        l = i;
        break;
      end
    end
    bus.i_cpu_req = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_vdu_read_en = 0; bus.i_vdu_read_addr = '0;
    tick(); tick();
    check("rst_ack", 16'(bus.o_cpu_ack), 0);
    check("rst_rdata", 16'(bus.o_cpu_rdata), 0);
    check("rst_vdu", 16'(bus.o_vdu_data), 0);
    rst_n = 1'b1;
    tick();
    cpu_op(1, 16'h0200, 8'h41, rd, lat);
    check("t1_wr_lat", 16'(lat), 1);
    tick();
    cpu_op(0, 16'h0200, 8'h00, rd, lat);
    check("t1_rd_lat", 16'(lat), 1);
    check("t1_rd_data", 16'(rd), 16'h41);
    tick();
    cpu_op(1, 16'h0200, 8'h11, rd, lat); tick();
    cpu_op(1, 16'h0201, 8'h22, rd, lat); tick();
    cpu_op(1, 16'h0205, 8'hAA, rd, lat); tick();
    check("t2_setup_lat", 16'(lat), 1);
    bus.i_vdu_read_en = 1; bus.i_vdu_read_addr = 16'h0200; tick();
    check("t2_vdu_c1", 16'(bus.o_vdu_data), 16'h11);
    tick();
    check("t2_vdu_c2", 16'(bus.o_vdu_data), 16'h11);
    bus.i_vdu_read_addr = 16'h0201; tick();
    check("t2_vdu_c3", 16'(bus.o_vdu_data), 16'h22);
    tick();
    bus.i_vdu_read_en = 0; tick();
    bus.i_vdu_read_en = 1; bus.i_vdu_read_addr = 16'h0200;
    bus.i_cpu_req = 1; bus.i_cpu_we = 1; bus.i_cpu_addr = 16'h0210; bus.i_cpu_wdata = 8'h77;
    tick();
    check("t3_ack_c1", 16'(bus.o_cpu_ack), 0);
    check("t3_vdu_c1", 16'(bus.o_vdu_data), 16'h11);
    bus.i_cpu_wdata = 8'h00;
    tick();
    check("t3_ack_c2", 16'(bus.o_cpu_ack), 1);
    check("t3_vdu_c2", 16'(bus.o_vdu_data), 16'h11);
    bus.i_cpu_req = 0; bus.i_vdu_read_addr = 16'h0201; tick();
    check("t3_ack_c3", 16'(bus.o_cpu_ack), 0);
    check("t3_vdu_c3", 16'(bus.o_vdu_data), 16'h22);
    bus.i_vdu_read_en = 0; tick();
    cpu_op(0, 16'h0210, 8'h00, rd, lat);
    check("t3_rd_back", 16'(rd), 16'h77);
    tick();
    acc = 0;
    bus.i_cpu_req = 1; bus.i_cpu_we = 0; bus.i_cpu_addr = 16'h0200;
    bus.i_vdu_read_en = 1;
    for (int i = 0; i < 10; i++) begin
      bus.i_vdu_read_addr = 16'h0200 + 16'(i);
      tick();
      acc |= bus.o_cpu_ack;
    end
    check("t4_starved", 16'(acc), 0);
    tick();
    check("t4_ack_after", 16'(bus.o_cpu_ack), 1);
    check("t4_rdata", 16'(bus.o_cpu_rdata), 16'h11);
    bus.i_cpu_req = 0; bus.i_vdu_read_en = 0; tick();
    bus.i_cpu_addr = 16'h01FF; #1 check("t5_hit_01ff", 16'(bus.o_cpu_hit), 0);
    bus.i_cpu_addr = 16'h03FF; #1 check("t5_hit_03ff", 16'(bus.o_cpu_hit), 1);
    bus.i_cpu_addr = 16'h0400; #1 check("t5_hit_0400", 16'(bus.o_cpu_hit), 0);
    bus.i_cpu_addr = 16'h0100; #1 check("t5_hit_0100", 16'(bus.o_cpu_hit), 0);
    cpu_op(1, 16'h0100, 8'h99, rd, lat);
    check("t5_noack_0100", 16'(lat), 16'hFFFF);
    cpu_op(1, 16'h0400, 8'h99, rd, lat);
    check("t5_noack_0400", 16'(lat), 16'hFFFF);
    cpu_op(0, 16'h0200, 8'h00, rd, lat);
    check("t5_ram_kept", 16'(rd), 16'h11);
    tick();
    bus.i_vdu_read_en = 1; bus.i_vdu_read_addr = 16'h0201; tick();
    check("t5_vdu_in", 16'(bus.o_vdu_data), 16'h22);
    bus.i_vdu_read_addr = 16'h0400; tick();
    check("t5_vdu_out", 16'(bus.o_vdu_data), 16'h00);
    bus.i_vdu_read_addr = 16'h0300;
    bus.i_cpu_req = 1; bus.i_cpu_we = 1; bus.i_cpu_addr = 16'h0205; bus.i_cpu_wdata = 8'h55;
    tick();
    check("t6_waiting", 16'(bus.o_cpu_ack), 0);
    bus.i_vdu_read_addr = 16'h0201;
    rst_n = 1'b0;
    #1;
    check("t6_ack0", 16'(bus.o_cpu_ack), 0);
    check("t6_rdata0", 16'(bus.o_cpu_rdata), 0);
    check("t6_vdu0", 16'(bus.o_vdu_data), 0);
    bus.i_cpu_req = 0; bus.i_vdu_read_en = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_ack", 16'(bus.o_cpu_ack), 0);
    cpu_op(0, 16'h0205, 8'h00, rd, lat);
    check("t6_ram_kept", 16'(rd), 16'hAA);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
